// File: rtl/picomem_slice_wdt.sv
// picomem_slice_wdt
//   Registered slice with a bus watchdog on the PicoMem native bus. It sits
//   between the PicoRV32 memory port and the address decoder. Every master
//   request is registered before it reaches the slave side. An access that
//   no slave ever acknowledges is terminated after TIMEOUT_CYCLES BUSY cycles.
//   That access returns TIMEOUT_RDATA and pulses timeout_irq.
//
//   Optional feature macro: PICOMEM_SLICE_WDT_TIMEOUT_EN
//     defined   : watchdog counter, timeout_irq and timeout_addr are present.
//     undefined : BUSY waits for picos_ready forever. timeout_irq and
//                 timeout_addr are tied to 0.
//
// Ports
//   clk, resetn              clock (rising edge), async active-low reset
//   picom_valid/addr/wdata/wstrb   master request (held until picom_ready)
//   picom_ready, picom_rdata       one-cycle completion and registered rdata
//   picos_valid/addr/wdata/wstrb   registered request toward the decoder
//   picos_ready, picos_rdata       slave completion and read data
//   timeout_irq, timeout_addr      forced-termination pulse and last timed-out address
module picomem_slice_wdt #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        picom_valid,
  input  logic [31:0] picom_addr,
  input  logic [31:0] picom_wdata,
  input  logic [3:0]  picom_wstrb,
  output logic        picom_ready,
  output logic [31:0] picom_rdata,
  output logic        picos_valid,
  output logic [31:0] picos_addr,
  output logic [31:0] picos_wdata,
  output logic [3:0]  picos_wstrb,
  input  logic        picos_ready,
  input  logic [31:0] picos_rdata,
  output logic        timeout_irq,
  output logic [31:0] timeout_addr
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;

`ifdef PICOMEM_SLICE_WDT_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  // The counter is cleared on every BUSY entry and stops at TERM, so it never wraps.
  logic [CW-1:0] wdt_cnt;
  logic          wdt_hit;
  assign wdt_hit = (wdt_cnt == TERM);
`else
  assign timeout_irq  = 1'b0;
  assign timeout_addr = 32'h0;
  // The watchdog parameters have no effect in this build.
  logic unused_params;
  assign unused_params = ^{TIMEOUT_RDATA, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      picos_valid <= 1'b0;
      picom_ready <= 1'b0;
      picos_addr  <= 32'h0;
      picos_wdata <= 32'h0;
      picos_wstrb <= 4'h0;
      picom_rdata <= 32'h0;
`ifdef PICOMEM_SLICE_WDT_TIMEOUT_EN
      wdt_cnt      <= '0;
      timeout_irq  <= 1'b0;
      timeout_addr <= 32'h0;
`endif
    end else begin
      // picom_ready and timeout_irq are single-cycle pulses.
      picom_ready <= 1'b0;
`ifdef PICOMEM_SLICE_WDT_TIMEOUT_EN
      timeout_irq <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (picom_valid) begin
            picos_addr  <= picom_addr;
            picos_wdata <= picom_wdata;
            picos_wstrb <= picom_wstrb;
            picos_valid <= 1'b1;
`ifdef PICOMEM_SLICE_WDT_TIMEOUT_EN
            wdt_cnt     <= '0;
`endif
            state       <= BUSY;
          end
        end
        BUSY: begin
          // picom_valid is ignored here. The captured access always completes.
          // If picos_ready arrives on the terminal count, ready has priority.
          if (picos_ready) begin
            picom_rdata <= picos_rdata;
            picos_valid <= 1'b0;
            picom_ready <= 1'b1;
            state       <= RESP;
          end
`ifdef PICOMEM_SLICE_WDT_TIMEOUT_EN
          else if (wdt_hit) begin
            picom_rdata  <= TIMEOUT_RDATA;
            timeout_irq  <= 1'b1;
            timeout_addr <= picos_addr;
            picos_valid  <= 1'b0;
            picom_ready  <= 1'b1;
            state        <= RESP;
          end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picomem_slice_wdt.sv
module tb_picomem_slice_wdt;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        picom_valid = 1'b0;
  logic [31:0] picom_addr = '0, picom_wdata = '0;
  logic [3:0]  picom_wstrb = '0;
  logic        picom_ready;
  logic [31:0] picom_rdata;
  logic        picos_valid;
  logic [31:0] picos_addr, picos_wdata;
  logic [3:0]  picos_wstrb;
  logic        picos_ready = 1'b0;
  logic [31:0] picos_rdata = '0;
  logic        timeout_irq;
  logic [31:0] timeout_addr;

  picomem_slice_wdt #(.TIMEOUT_CYCLES(16), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .picom_valid(picom_valid), .picom_addr(picom_addr), .picom_wdata(picom_wdata),
    .picom_wstrb(picom_wstrb), .picom_ready(picom_ready), .picom_rdata(picom_rdata),
    .picos_valid(picos_valid), .picos_addr(picos_addr), .picos_wdata(picos_wdata),
    .picos_wstrb(picos_wstrb), .picos_ready(picos_ready), .picos_rdata(picos_rdata),
    .timeout_irq(timeout_irq), .timeout_addr(timeout_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // picom_ready must never stay high for two consecutive cycles.
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (prev_rdy) chk("ready_one_cycle", {31'h0, picom_ready}, 32'h0);
    prev_rdy = picom_ready;
  end

  // This task drives one master access and acts as the slave.
  // The slave asserts ready in BUSY cycle number waitn+1; waitn<0 means the slave never answers.
  // lat counts clock edges from the capture edge up to and including the edge that raises picom_ready.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int waitn, input logic [31:0] srd,
                         output logic [31:0] rd, output int lat, output int busy,
                         output logic irq, output int unstable, output int rdy_cyc);
    bit done;
    @(negedge clk);
    picom_valid = 1'b1; picom_addr = a; picom_wdata = wd; picom_wstrb = ws;
    picos_ready = 1'b0;
    lat = 0; busy = 0; unstable = 0; done = 0; rd = 'x; irq = 1'bx; rdy_cyc = 0;
    while (!done && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (picom_ready) begin
        done = 1; rd = picom_rdata; irq = timeout_irq; rdy_cyc = cyc;
        if (picos_valid) unstable++;
      end else if (picos_valid) begin
        busy++;
        if (picos_addr !== a || picos_wdata !== wd || picos_wstrb !== ws) unstable++;
        if (busy == waitn + 1) begin picos_ready = 1'b1; picos_rdata = srd; end
        else picos_ready = 1'b0;
      end
    end
    if (!done) chk("txn_completed", 32'h0, 32'h1);
    picom_valid = 1'b0;
    picos_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waitn;
    logic [31:0] srd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [31:0] rd;
    int lat, busy, unstable, rc0, rc1;
    logic irq;

    vt[0] = '{"rd_fast",   32'h4000_0010, 32'h0,         4'b0000, 0,  32'h1234_5678, 32'h1234_5678, 2,  1};
    vt[1] = '{"wr_wait5",  32'h8000_0004, 32'hA5A5_A5A5, 4'b0011, 5,  32'h0BAD_F00D, 32'h0BAD_F00D, 7,  6};
    vt[2] = '{"rd_last16", 32'h0000_0100, 32'h0,         4'b0000, 15, 32'h0000_00AA, 32'h0000_00AA, 17, 16};
    vt[3] = '{"rd_wait2",  32'h2000_0000, 32'h0,         4'b0000, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4,  3};

    // Check the values held while reset is asserted.
    #2;
    chk("rst_picos_valid",  {31'h0, picos_valid}, 32'h0);
    chk("rst_picom_ready",  {31'h0, picom_ready}, 32'h0);
    chk("rst_timeout_irq",  {31'h0, timeout_irq}, 32'h0);
    chk("rst_picos_addr",   picos_addr, 32'h0);
    chk("rst_picos_wdata",  picos_wdata, 32'h0);
    chk("rst_picos_wstrb",  {28'h0, picos_wstrb}, 32'h0);
    chk("rst_picom_rdata",  picom_rdata, 32'h0);
    chk("rst_timeout_addr", timeout_addr, 32'h0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);

    // Apply the vector table.
    for (int i = 0; i < 4; i++) begin
      run_txn(vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].waitn, vt[i].srd, rd, lat, busy, irq, unstable, rc0);
      chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
      chk({vt[i].name, "_latency"}, 32'(lat), 32'(vt[i].exp_lat));
      chk({vt[i].name, "_busy_cycles"}, 32'(busy), 32'(vt[i].exp_busy));
      chk({vt[i].name, "_irq"}, {31'h0, irq}, 32'h0);
      chk({vt[i].name, "_stable"}, 32'(unstable), 32'h0);
      @(negedge clk);
      chk({vt[i].name, "_rdata_hold"}, picom_rdata, vt[i].exp_rd);
    end

    // Back-to-back reads. The second access starts in the IDLE cycle right after RESP.
    run_txn(32'h4000_0020, 32'h0, 4'h0, 0, 32'h1111_1111, rd, lat, busy, irq, unstable, rc0);
    chk("b2b_first_rdata", rd, 32'h1111_1111);
    run_txn(32'h4000_0024, 32'h0, 4'h0, 0, 32'h2222_2222, rd, lat, busy, irq, unstable, rc1);
    chk("b2b_second_rdata", rd, 32'h2222_2222);
    chk("b2b_cadence", 32'(rc1 - rc0), 32'd3);
    chk("b2b_second_stable", 32'(unstable), 32'h0);
    @(negedge clk);

`ifdef PICOMEM_SLICE_WDT_TIMEOUT_EN
    // The slave never answers, so the watchdog fires after 16 BUSY cycles.
    run_txn(32'hF000_0000, 32'h0, 4'h0, -1, 32'h0, rd, lat, busy, irq, unstable, rc0);
    chk("to_rdata", rd, 32'hDEAD_BEEF);
    chk("to_busy_cycles", 32'(busy), 32'd16);
    chk("to_latency", 32'(lat), 32'd17);
    chk("to_irq", {31'h0, irq}, 32'h1);
    chk("to_addr", timeout_addr, 32'hF000_0000);
    @(negedge clk);
    chk("to_irq_pulse", {31'h0, timeout_irq}, 32'h0);
    chk("to_addr_hold", timeout_addr, 32'hF000_0000);
`else
    // No watchdog in this build: a slow slave is waited for indefinitely.
    run_txn(32'hF000_0000, 32'h0, 4'h0, 40, 32'h5555_AAAA, rd, lat, busy, irq, unstable, rc0);
    chk("nowdt_rdata", rd, 32'h5555_AAAA);
    chk("nowdt_busy_cycles", 32'(busy), 32'd41);
    chk("nowdt_irq", {31'h0, irq}, 32'h0);
    chk("nowdt_addr", timeout_addr, 32'h0);
    @(negedge clk);
`endif

    // Assert reset in the 3rd BUSY cycle. The access must abort with no clock edge.
    @(negedge clk);
    picom_valid = 1'b1; picom_addr = 32'h1000_0040; picom_wdata = 32'hCAFE_0001; picom_wstrb = 4'hF;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rstmid_busy", {31'h0, picos_valid}, 32'h1);
    #1 resetn = 1'b0;
    #1;
    chk("rstmid_picos_valid", {31'h0, picos_valid}, 32'h0);
    chk("rstmid_picom_ready", {31'h0, picom_ready}, 32'h0);
    chk("rstmid_picos_addr", picos_addr, 32'h0);
    chk("rstmid_picom_rdata", picom_rdata, 32'h0);
    chk("rstmid_timeout_addr", timeout_addr, 32'h0);
    picom_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rstmid_no_ready", {31'h0, picom_ready}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    run_txn(32'h4000_0030, 32'h0, 4'h0, 1, 32'h7777_0000, rd, lat, busy, irq, unstable, rc0);
    chk("post_rst_rdata", rd, 32'h7777_0000);
    chk("post_rst_latency", 32'(lat), 32'd3);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
